// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//  Shared definitions for the 16-bit processor control path.
//  - opcode_t : instruction opcodes held in ir[8:6]
//  - state_t  : control FSM timesteps T0..T3
//  - SEL_*    : bus_multiplexer select codes for the non-register sources.
//               bus_multiplexer uses the same constants.
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Codes 0..7 select R0..R7 directly.
  localparam logic [3:0] SEL_DIN  = 4'd8;
  localparam logic [3:0] SEL_IDLE = 4'd9;
  localparam logic [3:0] SEL_G    = 4'd10;

endpackage

// File: rtl/processor_control_unit_if.sv
// -----------------------------------------------------------------------------
// processor_control_unit_if
//  Bundles the control unit's handshake and datapath-control signals.
//  Modports:
//   master : the control unit (drives ir/bus_sel/enables/status,
//            reads run/din/g_nz)
//   slave  : the datapath side (opposite directions)
//  Signals:
//   run, din[15:0], g_nz            -> into the control unit
//   ir[IR_W-1:0], bus_sel[3:0],
//   reg_in[NUM_REGS-1:0], a_in,
//   g_in, addsub, busy, done        -> out of the control unit
// -----------------------------------------------------------------------------
interface processor_control_unit_if #(
  parameter int NUM_REGS = 8,
  parameter int IR_W     = 9
);
  logic                run;
  logic [15:0]         din;
  logic                g_nz;
  logic [IR_W-1:0]     ir;
  logic [3:0]          bus_sel;
  logic [NUM_REGS-1:0] reg_in;
  logic                a_in;
  logic                g_in;
  logic                addsub;
  logic                busy;
  logic                done;

  modport master (
    input  run, din, g_nz,
    output ir, bus_sel, reg_in, a_in, g_in, addsub, busy, done
  );

  modport slave (
    output run, din, g_nz,
    input  ir, bus_sel, reg_in, a_in, g_in, addsub, busy, done
  );
endinterface

// File: rtl/reg_onehot_dec.sv
// -----------------------------------------------------------------------------
// reg_onehot_dec
//  Converts a register index plus write enable into the one-hot register-file
//  write-enable vector. All bits are low when the enable is low.
//  Ports:
//   i_idx    in  IDX_W     register index
//   i_en     in  1         write enable
//   o_onehot out NUM_REGS  one-hot write enable (zero when !i_en)
// -----------------------------------------------------------------------------
module reg_onehot_dec #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/processor_control_unit.sv
// -----------------------------------------------------------------------------
// processor_control_unit
//  Control FSM for the 16-bit processor datapath. Fetches a 9-bit instruction
//  {op, rx, ry} from din when run is high in T0. It then sequences the bus
//  select, register write enables, A/G loads and add/sub control over 2 cycles
//  (mv/mvi/mvnz/illegal) or 4 cycles (add/sub).
//  Ports:
//   clk     in   1   rising-edge clock
//   resetn  in   1   asynchronous active-low reset
//   bus     master modport of processor_control_unit_if
//                    (run/din/g_nz in; ir/bus_sel/reg_in/a_in/g_in/addsub/
//                     busy/done out)
//  Only the state register and IR are flops; every other output is decoded
//  combinationally from {state, ir, run, g_nz}.
// -----------------------------------------------------------------------------
module processor_control_unit
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IR_W     = 9
) (
  input  logic                     clk,
  input  logic                     resetn,
  processor_control_unit_if.master bus
);

  localparam logic [1:0] S_T0 = T0;
  localparam logic [1:0] S_T1 = T1;
  localparam logic [1:0] S_T2 = T2;
  localparam logic [1:0] S_T3 = T3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [IR_W-1:0]     r_ir;

  logic [2:0]          w_op;
  logic [2:0]          w_rx;
  logic [2:0]          w_ry;

  logic [3:0]          w_bus_sel;
  logic                w_wr_en;
  logic                w_a_in;
  logic                w_g_in;
  logic                w_addsub;
  logic                w_done;
  logic                w_ir_load;
  logic [NUM_REGS-1:0] w_reg_in;

  // Upper din bits carry no instruction information.
  logic                w_unused_din;
  assign w_unused_din = &{1'b0, bus.din[15:IR_W]};

  assign w_op = r_ir[8:6];
  assign w_rx = r_ir[5:3];
  assign w_ry = r_ir[2:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load) r_ir <= bus.din[IR_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = S_T0;
    w_bus_sel   = SEL_IDLE;
    w_wr_en     = 1'b0;
    w_a_in      = 1'b0;
    w_g_in      = 1'b0;
    w_addsub    = 1'b0;
    w_done      = 1'b0;
    w_ir_load   = 1'b0;

    case (r_state)
      S_T0: begin
        // run is only looked at here, so it is ignored while busy.
        if (bus.run) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_T1;
        end else begin
          w_state_nxt = S_T0;
        end
      end

      S_T1: begin
        case (w_op)
          OP_MV: begin
            w_bus_sel = {1'b0, w_ry};
            w_wr_en   = 1'b1;
            w_done    = 1'b1;
          end
          OP_MVI: begin
            w_bus_sel = SEL_DIN;
            w_wr_en   = 1'b1;
            w_done    = 1'b1;
          end
          OP_MVNZ: begin
            // A failed condition still completes the instruction, with no write.
            if (bus.g_nz) begin
              w_bus_sel = {1'b0, w_ry};
              w_wr_en   = 1'b1;
            end
            w_done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_bus_sel   = {1'b0, w_rx};
            w_a_in      = 1'b1;
            w_state_nxt = S_T2;
          end
          default: begin
            // Illegal opcodes retire as a no-op.
            w_done = 1'b1;
          end
        endcase
      end

      S_T2: begin
        // Only add/sub reach T2; anything else falls back to T0 idle.
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          w_bus_sel   = {1'b0, w_ry};
          w_g_in      = 1'b1;
          w_addsub    = (w_op == OP_SUB);
          w_state_nxt = S_T3;
        end
      end

      S_T3: begin
        w_bus_sel = SEL_G;
        w_wr_en   = 1'b1;
        w_done    = 1'b1;
      end

      default: begin
        w_state_nxt = S_T0;
      end
    endcase
  end

  // Every register write targets rx, so the decoder index is fixed.
  reg_onehot_dec #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_dec (
    .i_idx    (w_rx),
    .i_en     (w_wr_en),
    .o_onehot (w_reg_in)
  );

  assign bus.ir      = r_ir;
  assign bus.bus_sel = w_bus_sel;
  assign bus.reg_in  = w_reg_in;
  assign bus.a_in    = w_a_in;
  assign bus.g_in    = w_g_in;
  assign bus.addsub  = w_addsub;
  assign bus.done    = w_done;
  assign bus.busy    = (r_state != S_T0);

endmodule
